// File: rtl/cpu4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu4_pkg
//  Description : Shared widths, opcode and controller-state encodings for the
//                4-bit accumulator CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu4_pkg;

  localparam int DATA_W    = 4;
  localparam int INSTR_W   = 8;
  localparam int MEM_DEPTH = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_STA = 4'h2,
    OP_LDA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_NOT = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_JMP = 4'hC,
    OP_JZ  = 4'hD,
    OP_SLP = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH   = 3'b000,
    DECODE  = 3'b001,
    EXECUTE = 3'b010,
    SLEEP   = 3'b011,
    HALT    = 3'b100
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu4_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu4_alu
//  Description : Combinational ALU for the accumulator CPU. Arithmetic wraps
//                modulo 16; opcodes without an ALU result produce zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu4_alu
  import cpu4_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Result selection by opcode; non-ALU opcodes yield zero
  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  y = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  y = {1'b0, a[DATA_W-1:1]};
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu4_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu4_core
//  Description : 4-bit accumulator CPU with a 16x8 program memory and a
//                fetch/decode/execute controller plus SLEEP and HALT states.
//                The program image is preloaded hierarchically into memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu4_core
  import cpu4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wakeup,
  output logic [DATA_W-1:0] acc
);

  logic [3:0]         PC;
  logic [INSTR_W-1:0] IR;
  logic [3:0]         opcode;
  logic [3:0]         operand;
  logic [DATA_W-1:0]  R0;
  logic [DATA_W-1:0]  R1;
  logic [DATA_W-1:0]  alu_out;
  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  w_rn;

  // Program storage: written only by hierarchical preload, never reset
  logic [INSTR_W-1:0] memory [0:MEM_DEPTH-1];

  assign opcode  = IR[7:4];
  assign operand = IR[3:0];
  assign w_rn    = operand[0] ? R1 : R0;

  cpu4_alu u_alu (
    .opcode (opcode),
    .a      (acc),
    .b      (w_rn),
    .y      (alu_out)
  );

  // Controller state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state selection; wakeup only matters while sleeping
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: begin
        if (opcode == OP_SLP)      state_nxt = SLEEP;
        else if (opcode == OP_HLT) state_nxt = HALT;
        else                       state_nxt = FETCH;
      end
      SLEEP:   state_nxt = wakeup ? FETCH : SLEEP;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Datapath: instruction fetch and architectural register updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC  <= '0;
      IR  <= '0;
      acc <= '0;
      R0  <= '0;
      R1  <= '0;
    end else if (state == FETCH) begin
      IR <= memory[PC];
      PC <= PC + 4'd1;
    end else if (state == EXECUTE) begin
      case (opcode)
        OP_LDI: acc <= operand;
        OP_STA: begin
          if (operand[0]) R1 <= acc;
          else            R0 <= acc;
        end
        OP_LDA: acc <= w_rn;
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOT, OP_SHL, OP_SHR: acc <= alu_out;
        OP_JMP: PC <= operand;
        OP_JZ:  if (acc == '0) PC <= operand;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu4_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu4_core
//  Description : Self-checking bench for cpu4_core: directed program table,
//                multi-cycle reset/sleep sequences and random programs run
//                against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu4_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wakeup = 1'b0;
  logic [3:0] acc;

  int checks = 0;
  int failures = 0;

  // Instruction-level reference model state
  logic [7:0] m_mem [16];
  int m_pc, m_acc, m_r0, m_r1;
  bit m_halt;

  typedef struct packed {
    logic [127:0] prog;  // word 0 in the most significant byte
    logic [7:0]   n;     // instructions to run
    logic [3:0]   acc;
    logic [3:0]   pc;
    logic [3:0]   r0;
    logic [3:0]   r1;
    logic [2:0]   st;
  } vec_t;

  vec_t vecs [9];

  cpu4_core dut (
    .clk    (clk),
    .reset  (reset),
    .wakeup (wakeup),
    .acc    (acc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Hold reset, preload memory, release reset between clock edges
  task automatic load_and_reset(input logic [127:0] p);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dut.memory[i] = p[127-8*i -: 8];
      m_mem[i]      = p[127-8*i -: 8];
    end
    m_pc = 0; m_acc = 0; m_r0 = 0; m_r1 = 0; m_halt = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  // Executes one whole instruction with plain arithmetic (SLP not modelled)
  task automatic model_step();
    int op, opd, rn;
    op   = int'(m_mem[m_pc][7:4]);
    opd  = int'(m_mem[m_pc][3:0]);
    m_pc = (m_pc + 1) % 16;
    rn   = (opd % 2 == 1) ? m_r1 : m_r0;
    case (op)
      1:  m_acc = opd;
      2:  if (opd % 2 == 1) m_r1 = m_acc; else m_r0 = m_acc;
      3:  m_acc = rn;
      4:  m_acc = (m_acc + rn) % 16;
      5:  m_acc = (m_acc - rn + 16) % 16;
      6:  m_acc = m_acc & rn;
      7:  m_acc = m_acc | rn;
      8:  m_acc = m_acc ^ rn;
      9:  m_acc = 15 - m_acc;
      10: m_acc = (m_acc * 2) % 16;
      11: m_acc = m_acc / 2;
      12: m_pc = opd;
      13: if (m_acc == 0) m_pc = opd;
      15: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    logic [127:0] p;
    logic [7:0]   b;

    //            program                               n     acc    pc     r0     r1     state
    vecs[0] = '{128'h19201940_F0000000_00000000_00000000, 8'd5,  4'h2, 4'd5, 4'h9, 4'h0, 3'd4};
    vecs[1] = '{128'h1A211681_B090F000_00000000_00000000, 8'd7,  4'h9, 4'd7, 4'h0, 4'hA, 3'd4};
    vecs[2] = '{128'h10D51F1F_1FF00000_00000000_00000000, 8'd3,  4'h0, 4'd6, 4'h0, 4'h0, 3'd4};
    vecs[3] = '{128'h11D517F0_1FF00000_00000000_00000000, 8'd4,  4'h7, 4'd4, 4'h0, 4'h0, 3'd4};
    vecs[4] = '{128'h12C00000_00000000_00000000_00000000, 8'd6,  4'h2, 4'd0, 4'h0, 4'h0, 3'd0};
    vecs[5] = '{128'h00000000_00000000_00000000_0000001F, 8'd16, 4'hF, 4'd0, 4'h0, 4'h0, 3'd0};
    vecs[6] = '{128'h00000000_00000000_00000000_0000001F, 8'd17, 4'hF, 4'd1, 4'h0, 4'h0, 3'd0};
    vecs[7] = '{128'h15211351_71A061F0_00000000_00000000, 8'd8,  4'h4, 4'd8, 4'h0, 4'h5, 3'd4};
    vecs[8] = '{128'h17201230_90F00000_00000000_00000000, 8'd6,  4'h8, 4'd6, 4'h7, 4'h0, 3'd4};

    // Reset state before any edge is released
    #2;
    check("reset_state", {5'd0, dut.state}, 8'h00);
    check("reset_pc", {4'd0, dut.PC}, 8'h00);
    check("reset_acc", {4'd0, acc}, 8'h00);

    // Directed program table
    for (int v = 0; v < 9; v++) begin
      load_and_reset(vecs[v].prog);
      repeat (3 * int'(vecs[v].n)) tick();
      check($sformatf("vec%0d_acc", v), {4'd0, acc}, {4'd0, vecs[v].acc});
      check($sformatf("vec%0d_pc", v), {4'd0, dut.PC}, {4'd0, vecs[v].pc});
      check($sformatf("vec%0d_r0", v), {4'd0, dut.R0}, {4'd0, vecs[v].r0});
      check($sformatf("vec%0d_r1", v), {4'd0, dut.R1}, {4'd0, vecs[v].r1});
      check($sformatf("vec%0d_state", v), {5'd0, dut.state}, {5'd0, vecs[v].st});
    end

    // Halt is held for many cycles and stays put
    load_and_reset(vecs[0].prog);
    repeat (15 + 12) tick();
    check("halt_hold_state", {5'd0, dut.state}, 8'h04);
    check("halt_hold_acc", {4'd0, acc}, 8'h02);

    // Asynchronous reset mid-program, then fetch of address 0
    load_and_reset(vecs[4].prog);
    repeat (7) tick();
    #1;
    reset = 1'b0;
    #1;
    check("midrst_pc", {4'd0, dut.PC}, 8'h00);
    check("midrst_acc", {4'd0, acc}, 8'h00);
    check("midrst_r0", {4'd0, dut.R0}, 8'h00);
    check("midrst_r1", {4'd0, dut.R1}, 8'h00);
    check("midrst_ir", dut.IR, 8'h00);
    check("midrst_state", {5'd0, dut.state}, 8'h00);
    reset = 1'b1;
    tick();
    check("postrst_state", {5'd0, dut.state}, 8'h01);
    check("postrst_ir", dut.IR, 8'h12);
    check("postrst_pc", {4'd0, dut.PC}, 8'h01);

    // Sleep, wakeup pulse, then halt ignoring wakeup
    load_and_reset(128'h13E017F0_00000000_00000000_00000000);
    repeat (6) tick();
    check("sleep_enter", {5'd0, dut.state}, 8'h03);
    check("sleep_alu_zero", {4'd0, dut.alu_out}, 8'h00);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("sleep_hold_state", {5'd0, dut.state}, 8'h03);
      check("sleep_hold_acc", {4'd0, acc}, 8'h03);
    end
    wakeup = 1'b1;
    tick();
    wakeup = 1'b0;
    check("wake_state", {5'd0, dut.state}, 8'h00);
    check("wake_pc", {4'd0, dut.PC}, 8'h02);
    repeat (3) tick();
    check("wake_acc", {4'd0, acc}, 8'h07);
    repeat (3) tick();
    check("halt_state", {5'd0, dut.state}, 8'h04);
    wakeup = 1'b1;
    repeat (4) tick();
    wakeup = 1'b0;
    check("halt_wake_state", {5'd0, dut.state}, 8'h04);
    check("halt_wake_pc", {4'd0, dut.PC}, 8'h04);

    // Wakeup already high when SLP executes: one sleep cycle only
    load_and_reset(128'h13E017F0_00000000_00000000_00000000);
    wakeup = 1'b1;
    repeat (6) tick();
    check("wakehi_sleep", {5'd0, dut.state}, 8'h03);
    tick();
    check("wakehi_fetch", {5'd0, dut.state}, 8'h00);
    repeat (3) tick();
    check("wakehi_acc", {4'd0, acc}, 8'h07);
    wakeup = 1'b0;

    // Random programs against the instruction-level model
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) begin
        b = 8'($urandom);
        if (b[7:4] == 4'hE) b[7:4] = 4'h0;
        p[127-8*i -: 8] = b;
      end
      load_and_reset(p);
      for (int k = 0; k < 24 && !m_halt; k++) begin
        model_step();
        repeat (3) tick();
        check("rand_acc", {4'd0, acc}, 8'(m_acc));
        check("rand_pc", {4'd0, dut.PC}, 8'(m_pc));
        check("rand_r0", {4'd0, dut.R0}, 8'(m_r0));
        check("rand_r1", {4'd0, dut.R1}, 8'(m_r1));
        check("rand_state", {5'd0, dut.state}, m_halt ? 8'h04 : 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu4_core.md
# cpu4_core

4-bit accumulator CPU with a 16×8 instruction memory and a three-phase fetch/decode/execute controller. It also has a low-power SLEEP state that is left on an external `wakeup` strobe, and a terminal HALT state. It is the top-level compute block of the small-CPU subsystem; the only architectural output is the accumulator. The program image is loaded by hierarchical preload of the internal `memory` array; there is no write port.

## Interface
- No parameters. Widths are fixed: data 4 bits, instruction 8 bits, 16 memory words.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low. Low clears all state.
- `wakeup` input 1: exits SLEEP when sampled high on a rising edge. Ignored in every other state.
- `acc` output 4: accumulator register, driven directly.
- Internal signals must be visible for debug under exactly these names:
  - `PC`[3:0], `IR`[7:0], `opcode`[3:0] = `IR[7:4]`, `operand`[3:0] = `IR[3:0]`
  - `R0`[3:0], `R1`[3:0], `alu_out`[3:0], `state`[2:0]
  - `memory`[0:15][7:0]

## Operation
- States:
  - FETCH=000: `IR<=memory[PC]`, `PC<=PC+1` (mod 16), then go to DECODE.
  - DECODE=001: no register update, then go to EXECUTE.
  - EXECUTE=010: perform the instruction, then go to FETCH, unless the instruction is SLP or HLT.
  - SLEEP=011: hold all registers. Go to FETCH when `wakeup`=1, otherwise stay in SLEEP.
  - HALT=100: hold forever until reset.
- Register select for Rn instructions: Rn = R0 if `operand[0]`=0, else R1.
- Opcodes:
  - 0000 NOP
  - 0001 LDI: ACC<=operand
  - 0010 STA: Rn<=ACC
  - 0011 LDA: ACC<=Rn
  - 0100 ADD: ACC<=ACC+Rn
  - 0101 SUB: ACC<=ACC−Rn
  - 0110 AND: ACC<=ACC&Rn
  - 0111 OR: ACC<=ACC|Rn
  - 1000 XOR: ACC<=ACC^Rn
  - 1001 NOT: ACC<=~ACC
  - 1010 SHL: ACC<=ACC<<1, 0 shifted in
  - 1011 SHR: ACC<=ACC>>1, 0 shifted in
  - 1100 JMP: PC<=operand
  - 1101 JZ: PC<=operand if ACC==0
  - 1110 SLP: go to SLEEP
  - 1111 HLT: go to HALT
- ALU arithmetic is modulo 16; carry and borrow are discarded and there are no flags.
- `alu_out` is combinational from `opcode`, ACC and Rn. For opcodes outside 0100–1011 it is 0000.

## Timing
- Reset (asynchronous) clears PC, ACC, IR, R0 and R1 to 0 and sets `state`=FETCH.
- The first rising edge with `reset` high performs the fetch of `memory[0]`.
- Each instruction takes 3 cycles. Architectural results are visible on the cycle after the EXECUTE edge.
- Jumps override the FETCH increment. The next fetch uses the jump target.
- PC wraps from 15 to 0. Execution continues from address 0.
- `wakeup` high in SLEEP: the next edge enters FETCH at the PC after the SLP instruction.
- `wakeup` held high when SLP executes: SLEEP lasts exactly one cycle.
- Reset asserted in any state, including SLEEP or HALT, aborts immediately. Memory contents are not cleared.
- `wakeup` in HALT has no effect.

## Structure
- Package `cpu4_pkg`:
  - opcode enum (16 values above)
  - state enum (FETCH, DECODE, EXECUTE, SLEEP, HALT)
  - width constants (DATA_W=4, INSTR_W=8, MEM_DEPTH=16)
- Sub-module `cpu4_alu`: purely combinational. Inputs `opcode`, `a` (ACC) and `b` (Rn); output `y`.
- The controller, registers and memory stay in `cpu4_core`.

## Test plan
- Reset: hold `reset` low mid-program. Expect immediately PC=0, ACC=0, R0=R1=0, state=000; after release, FETCH of address 0.
- Arithmetic wrap: program LDI 9; STA R0; LDI 9; ADD R0; HLT. Expect ACC=2 after the ADD EXECUTE, then state=100 and held.
- Logic/shift: program LDI 1010; STA R1; LDI 0110; XOR R1; SHR; NOT. Expect ACC=1100, then 0110, then 1001.
- Branch:
  - LDI 0; JZ 5 → PC=5 on the cycle after EXECUTE.
  - LDI 1; JZ 5 → falls through.
  - JMP 0 → loops.
- Sleep/wakeup:
  - Program LDI 3; SLP; LDI 7. ACC stays 3 and state=011 for 20 cycles with `wakeup`=0.
  - Pulse `wakeup` for one cycle. Expect state=000 on the next edge and ACC=7 three cycles later.
  - `wakeup` asserted in HALT is ignored.
- PC wrap: 16 NOPs with the last word = LDI F. Expect PC 15→0 and execution continuing from address 0.
